// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions.
// Holds the default predictor widths and the branch update queue entry layout
// used by branch_update_queue. The entry fields take their widths from the
// package constants, so queue instances must use matching GHR/IDX widths.
package bp_pkg;

  localparam int GHR_WIDTH = 8;
  localparam int IDX_WIDTH = 8;
  localparam int BUQ_DEPTH = 8;

  // Prediction context captured at predict time.
  typedef struct packed {
    logic [31:0]          pc;
    logic [IDX_WIDTH-1:0] index;
    logic                 pred;
    logic [GHR_WIDTH-1:0] ghr;
  } buq_entry_t;

endpackage

// File: rtl/buq_ptr_ctrl.sv
// Pointer / occupancy control for the branch update queue.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   alloc_req           enqueue request (accepted only when not full)
//   resolve_req         dequeue request (accepted only when not empty)
//   flush               accepted dequeue is a mispredict: drop younger entries
//   enq, deq            accepted enqueue / dequeue this cycle
//   rd_addr, wr_addr    storage addresses of head and tail slot
//   count               registered occupancy
//   full, empty         derived from the registered pointers
module buq_ptr_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_req,
  input  logic                     resolve_req,
  input  logic                     flush,
  output logic                     enq,
  output logic                     deq,
  output logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr;

  assign full    = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign empty   = (rd_ptr == wr_ptr);
  assign enq     = alloc_req && !full;
  assign deq     = resolve_req && !empty;
  assign rd_addr = rd_ptr[AW-1:0];
  assign wr_addr = wr_ptr[AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (deq)
        rd_ptr <= rd_ptr + 1'b1;
      if (deq && flush) begin
        // Tail snaps to just past the resolved head; a same-cycle enqueue is
        // wrong-path and is dropped with the rest.
        wr_ptr <= rd_ptr + 1'b1;
        count  <= '0;
      end else begin
        if (enq)
          wr_ptr <= wr_ptr + 1'b1;
        if (enq && !deq)
          count <= count + 1'b1;
        else if (deq && !enq)
          count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_update_queue.sv
// In-order queue of in-flight branch predictions between a gshare predictor
// and execute. Captures pc/index/pred/GHR at predict time, pairs each entry
// with its in-order outcome and emits a one-cycle registered training pulse,
// flagging mispredicts, supplying the repaired GHR and flushing younger
// wrong-path entries.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   alloc_valid/ready, alloc_pc,
//   alloc_index, alloc_pred,
//   alloc_ghr                         enqueue of a predicted branch
//   resolve_valid/ready, resolve_taken outcome of the oldest branch
//   upd_valid, upd_taken, upd_pc,
//   upd_index, mispredict,
//   recover_ghr                       registered update pulse and context
//   count                             current occupancy
// Optional (macro BUQ_STATS_EN): stat_resolved, stat_mispredict saturating
// counters of update pulses and mispredicting update pulses.
module branch_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH     = BUQ_DEPTH,
  parameter int GHR_WIDTH = bp_pkg::GHR_WIDTH,
  parameter int IDX_WIDTH = bp_pkg::IDX_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [31:0]              alloc_pc,
  input  logic [IDX_WIDTH-1:0]     alloc_index,
  input  logic                     alloc_pred,
  input  logic [GHR_WIDTH-1:0]     alloc_ghr,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     resolve_ready,
  output logic                     upd_valid,
  output logic                     upd_taken,
  output logic [31:0]              upd_pc,
  output logic [IDX_WIDTH-1:0]     upd_index,
  output logic                     mispredict,
  output logic [GHR_WIDTH-1:0]     recover_ghr,
  output logic [$clog2(DEPTH):0]   count
`ifdef BUQ_STATS_EN
  ,
  output logic [31:0]              stat_resolved,
  output logic [31:0]              stat_mispredict
`endif
);

  localparam int AW = $clog2(DEPTH);

  buq_entry_t        mem [DEPTH];
  buq_entry_t        head;
  buq_entry_t        new_entry;
  logic              enq;
  logic              deq;
  logic              full;
  logic              empty;
  logic              head_wrong;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     wr_addr;

  buq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk         (clk),
    .reset       (reset),
    .alloc_req   (alloc_valid),
    .resolve_req (resolve_valid),
    .flush       (head_wrong),
    .enq         (enq),
    .deq         (deq),
    .rd_addr     (rd_addr),
    .wr_addr     (wr_addr),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  assign alloc_ready   = !full;
  assign resolve_ready = !empty;
  assign head          = mem[rd_addr];
  assign head_wrong    = (head.pred != resolve_taken);

  always_comb begin
    new_entry       = '0;
    new_entry.pc    = alloc_pc;
    new_entry.index = alloc_index;
    new_entry.pred  = alloc_pred;
    new_entry.ghr   = alloc_ghr;
  end

  // Entry storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (enq)
      mem[wr_addr] <= new_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid   <= 1'b0;
      upd_taken   <= 1'b0;
      upd_pc      <= '0;
      upd_index   <= '0;
      mispredict  <= 1'b0;
      recover_ghr <= '0;
    end else begin
      upd_valid <= deq;
      if (deq) begin
        upd_taken   <= resolve_taken;
        upd_pc      <= head.pc;
        upd_index   <= head.index;
        mispredict  <= head_wrong;
        recover_ghr <= {head.ghr[GHR_WIDTH-2:0], resolve_taken};
      end
    end
  end

`ifdef BUQ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else begin
      if (upd_valid && (stat_resolved != '1))
        stat_resolved <= stat_resolved + 1'b1;
      if (upd_valid && mispredict && (stat_mispredict != '1))
        stat_mispredict <= stat_mispredict + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
module tb_branch_update_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [31:0] alloc_pc;
  logic [7:0]  alloc_index;
  logic        alloc_pred;
  logic [7:0]  alloc_ghr;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        resolve_ready;
  logic        upd_valid;
  logic        upd_taken;
  logic [31:0] upd_pc;
  logic [7:0]  upd_index;
  logic        mispredict;
  logic [7:0]  recover_ghr;
  logic [3:0]  count;
`ifdef BUQ_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispredict;
`endif

  branch_update_queue #(.DEPTH(DEPTH), .GHR_WIDTH(8), .IDX_WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_pc      (alloc_pc),
    .alloc_index   (alloc_index),
    .alloc_pred    (alloc_pred),
    .alloc_ghr     (alloc_ghr),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .resolve_ready (resolve_ready),
    .upd_valid     (upd_valid),
    .upd_taken     (upd_taken),
    .upd_pc        (upd_pc),
    .upd_index     (upd_index),
    .mispredict    (mispredict),
    .recover_ghr   (recover_ghr),
    .count         (count)
`ifdef BUQ_STATS_EN
    ,
    .stat_resolved   (stat_resolved),
    .stat_mispredict (stat_mispredict)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  idx;
    logic        pred;
    logic [7:0]  ghr;
  } ent_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  idx;
    logic        taken;
    logic        misp;
    logic [7:0]  rghr;
  } exp_t;

  ent_t mq[$];     // reference queue contents
  exp_t exp_q[$];  // expected update pulses, in order

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every update pulse is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && upd_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got upd_valid=1 expected no pulse at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("upd_pc", upd_pc, e.pc);
        chk("upd_index", {24'h0, upd_index}, {24'h0, e.idx});
        chk("upd_taken", {31'h0, upd_taken}, {31'h0, e.taken});
        chk("mispredict", {31'h0, mispredict}, {31'h0, e.misp});
        chk("recover_ghr", {24'h0, recover_ghr}, {24'h0, e.rghr});
      end
    end
  end

  // One clock of stimulus; pushes the expected pulse and updates the model.
  task automatic step(input logic a_v, input logic [31:0] pc, input logic [7:0] idx,
                      input logic pred, input logic [7:0] ghr,
                      input logic r_v, input logic taken);
    logic acc_a, acc_r, misp;
    ent_t h;
    exp_t e;
    alloc_valid   = a_v;
    alloc_pc      = pc;
    alloc_index   = idx;
    alloc_pred    = pred;
    alloc_ghr     = ghr;
    resolve_valid = r_v;
    resolve_taken = taken;
    acc_a = a_v && (mq.size() < DEPTH);
    acc_r = r_v && (mq.size() > 0);
    misp  = 1'b0;
    if (acc_r) begin
      h      = mq[0];
      misp   = (h.pred != taken);
      e.pc   = h.pc;
      e.idx  = h.idx;
      e.taken = taken;
      e.misp = misp;
      e.rghr = {h.ghr[6:0], taken};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (acc_r) void'(mq.pop_front());
    if (misp) mq.delete();
    else if (acc_a) mq.push_back('{pc: pc, idx: idx, pred: pred, ghr: ghr});
    chk("pulse_latency", {31'h0, upd_valid}, {31'h0, acc_r});
    chk("count", {28'h0, count}, mq.size());
    chk("alloc_ready", {31'h0, alloc_ready}, {31'h0, mq.size() < DEPTH});
    chk("resolve_ready", {31'h0, resolve_ready}, {31'h0, mq.size() > 0});
    alloc_valid   = 1'b0;
    resolve_valid = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [7:0] idx, input logic pred, input logic [7:0] ghr);
    step(1'b1, pc, idx, pred, ghr, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic taken);
    step(1'b0, 32'h0, 8'h0, 1'b0, 8'h0, 1'b1, taken);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    alloc_valid = 1'b0; alloc_pc = '0; alloc_index = '0; alloc_pred = 1'b0; alloc_ghr = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
    #2;
    chk("reset_count", {28'h0, count}, 32'd0);
    chk("reset_upd_valid", {31'h0, upd_valid}, 32'd0);
    chk("reset_upd_pc", upd_pc, 32'd0);
    chk("reset_recover_ghr", {24'h0, recover_ghr}, 32'd0);
    chk("reset_alloc_ready", {31'h0, alloc_ready}, 32'd1);
    chk("reset_resolve_ready", {31'h0, resolve_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // In-order correct resolves.
    alloc(32'h100, 8'h10, 1'b1, 8'h11);
    alloc(32'h104, 8'h20, 1'b0, 8'h22);
    alloc(32'h108, 8'h30, 1'b1, 8'h33);
    resolve(1'b1);
    resolve(1'b0);
    resolve(1'b1);
    chk("t1_count_zero", {28'h0, count}, 32'd0);

    // Fill, hold a rejected alloc, then resolve while full with alloc pending.
    for (int i = 0; i < 8; i++) alloc(32'h300 + 32'(i * 4), 8'(i), 1'b1, 8'(i));
    chk("full_count", {28'h0, count}, 32'd8);
    chk("full_alloc_ready", {31'h0, alloc_ready}, 32'd0);
    alloc(32'h400, 8'hFF, 1'b1, 8'h00);
    alloc(32'h400, 8'hFF, 1'b1, 8'h00);
    step(1'b1, 32'h404, 8'hFE, 1'b1, 8'h00, 1'b1, 1'b1);
    chk("after_full_alloc_ready", {31'h0, alloc_ready}, 32'd1);
    chk("after_full_count", {28'h0, count}, 32'd7);
    for (int i = 0; i < 7; i++) resolve(1'b1);

    // Mispredict at the head flushes younger entries and the same-cycle alloc.
    alloc(32'h500, 8'h50, 1'b0, 8'hA5);
    alloc(32'h504, 8'h51, 1'b1, 8'h01);
    alloc(32'h508, 8'h52, 1'b1, 8'h02);
    alloc(32'h50C, 8'h53, 1'b1, 8'h03);
    step(1'b1, 32'h510, 8'h54, 1'b1, 8'h04, 1'b1, 1'b1);
    chk("misp_flag", {31'h0, mispredict}, 32'd1);
    chk("misp_recover_ghr", {24'h0, recover_ghr}, 32'h4B);
    chk("misp_pc", upd_pc, 32'h500);
    chk("misp_count", {28'h0, count}, 32'd0);
    chk("misp_resolve_ready", {31'h0, resolve_ready}, 32'd0);
    alloc(32'h520, 8'h60, 1'b1, 8'h05);
    resolve(1'b1);

    // Steady state at occupancy 3; pointers wrap several times.
    for (int i = 0; i < 3; i++) alloc(32'h600 + 32'(i * 4), 8'(8'h80 + i), i[0], 8'(i));
    for (int i = 3; i < 23; i++) begin
      step(1'b1, 32'h600 + 32'(i * 4), 8'(8'h80 + i), i[0], 8'(i), 1'b1, mq[0].pred);
      chk("steady_count", {28'h0, count}, 32'd3);
    end
    for (int i = 0; i < 3; i++) resolve(mq[0].pred);

    // Resolve on empty queue is ignored.
    resolve(1'b1);
    idle();
    chk("empty_resolve_count", {28'h0, count}, 32'd0);

    // Reset mid-operation with an update pending.
    for (int i = 0; i < 5; i++) alloc(32'h700 + 32'(i * 4), 8'(i), 1'b1, 8'(i));
    alloc_valid = 1'b0;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    @(posedge clk);
    #1;
    resolve_valid = 1'b0;
    chk("pre_reset_pulse", {31'h0, upd_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_reset_upd_valid", {31'h0, upd_valid}, 32'd0);
    chk("mid_reset_count", {28'h0, count}, 32'd0);
    chk("mid_reset_resolve_ready", {31'h0, resolve_ready}, 32'd0);
    exp_q.delete();
    mq.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
    alloc(32'h800, 8'h12, 1'b0, 8'h34);
    resolve(1'b0);

`ifdef BUQ_STATS_EN
    reset = 1'b1;
    #1;
    chk("stats_reset", stat_resolved, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      alloc(32'h900 + 32'(i * 4), 8'(i), 1'b1, 8'(i));
      resolve((i == 2 || i == 5 || i == 8) ? 1'b0 : 1'b1);
    end
    idle();
    idle();
    chk("stat_resolved", stat_resolved, 32'd10);
    chk("stat_mispredict", stat_mispredict, 32'd3);
`endif

    idle();
    idle();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
